// File: rtl/reg_file_4x4b.sv
// 4x4-bit register file with busy scoreboard; writes land in 1 cycle, reads and busy are combinational.
// stall flags a pending operand; optional same-cycle write forwarding under `REGFILE_BYPASS_EN.
module reg_file_4x4b #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             issue,
  input  logic [1:0]       iaddr,
  input  logic [1:0]       raddr_a,
  input  logic [1:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic             stall
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Issue is applied after the write so a same-register collision leaves the new producer busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    if (issue) begin
      busy_d[iaddr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    busy_a  = busy_q[raddr_a];
    busy_b  = busy_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
    // Forwarded data is valid now, so the port is never busy even if re-issued this cycle.
    if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
      busy_a  = 1'b0;
    end
    if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
      busy_b  = 1'b0;
    end
`else
`endif
    stall = busy_a | busy_b;
  end

endmodule

// File: doc/reg_file_4x4b.md
Name: reg_file_4x4b

Overview:
- 4-entry x 4-bit general register file for the 4-bit CPU datapath.
- Sits directly upstream of the operand-select muxes: each read port presents one register's 4-bit value per cycle, chosen by a 2-bit address (addr[1] acts as the high select, addr[0] as the low select).
- Also keeps a per-register busy scoreboard so the control unit can stall on operands not yet written back.

Parameters:
- WIDTH, 4, data width of each register in bits.
- DEPTH, 4, number of registers; fixed at 4 (2-bit addresses). Other values are unsupported.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- we  input  1  write enable for the write-back port
- waddr  input  2  write-back register address
- wdata  input  4  write-back data
- issue  input  1  marks register iaddr busy (instruction issued targeting it)
- iaddr  input  2  destination register of the issued instruction
- raddr_a  input  2  read port A address
- raddr_b  input  2  read port B address
- rdata_a  output  4  read port A data
- rdata_b  output  4  read port B data
- busy_a  output  1  register at raddr_a has a pending write
- busy_b  output  1  register at raddr_b has a pending write
- stall  output  1  busy_a OR busy_b

Behaviour:
- Clock and reset: clk is the only clock; rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - all four registers clear to 4'h0;
  - all busy bits clear to 0;
  - outputs reflect the reset state combinationally from the next cycle: rdata_* = 0, busy_* = 0, stall = 0.
  - rst has priority over we and issue in the same cycle. A write or issue presented during reset is discarded.
- Write:
  - we=1 at a rising edge stores wdata into reg[waddr] and clears busy[waddr].
  - Write latency is 1 cycle: the new value is visible on reads in the cycle after the edge.
- Read:
  - rdata_a = reg[raddr_a] and rdata_b = reg[raddr_b], purely combinational from the stored state; 0-cycle read latency.
  - Both ports may address the same register.
- Scoreboard:
  - issue=1 at a rising edge sets busy[iaddr].
  - busy_a = busy[raddr_a], busy_b = busy[raddr_b], both combinational.
- Simultaneous issue and write:
  - Different addresses: both take effect.
  - Same address: busy ends up SET, because a new producer was issued after the old one completed. The register data is still updated with wdata.
- Read of a register being written in the same cycle: returns the OLD value (no bypass) unless the optional feature is compiled in.
- Redundant or out-of-order operations:
  - issue to an already-busy register leaves it busy.
  - A write to a non-busy register is legal; data updates and busy stays 0.
- Address wrap: 2-bit addresses cover 0..3 exactly; there are no out-of-range cases.
- Reset mid-operation: all pending busy bits are discarded. A write-back arriving after reset behaves as an ordinary write to a non-busy register.
- State is 16 data flops plus 4 busy flops; there is no other FSM.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - when we=1 and waddr equals a read address in the same cycle, that port outputs wdata combinationally;
  - the matching busy_* output reads 0 unless issue targets the same register in that cycle, in which case busy is still forced to 0 for that cycle only (the bypassed data is valid now);
  - stall follows the adjusted busy outputs.
- Undefined: no forwarding; reads return stored values, busy reflects the stored busy bits, and a same-cycle write is visible only from the next cycle.

Test Plan:
1. Reset then read: assert rst 1 cycle, raddr_a=0..3 -> rdata_a=0, busy_a=0, stall=0 for every address.
2. Write/readback: we=1, waddr=2, wdata=4'hA; next cycle raddr_a=2, raddr_b=2 -> rdata_a=rdata_b=4'hA. Other registers remain 0.
3. Scoreboard: issue with iaddr=1; next cycle raddr_b=1 -> busy_b=1, stall=1. Write waddr=1, wdata=4'h5; next cycle -> busy_b=0, stall=0, rdata_b=4'h5.
4. Same-cycle issue and write to reg 3 (reg 3 busy beforehand) -> after the edge busy[3]=1 and reg[3]=wdata.
5. Same-cycle write and read of reg 0 with wdata=4'hF, old value 4'h0:
   - without REGFILE_BYPASS_EN -> rdata_a=4'h0 in that cycle, 4'hF in the next;
   - with the macro -> rdata_a=4'hF in the same cycle.
6. Reset mid-operation: regs hold 1,2,3,4 and busy=4'b1010; assert rst together with we=1, waddr=0, wdata=4'h7 -> all regs 0, all busy 0, and the write is dropped.
